// File: rtl/gcm_tag_verifier.sv
// gcm_tag_verifier: GHASH accumulator with a bit-serial GF(2^128) multiplier.
// The computed tag (GHASH XOR E(K,J0)) is compared against a received tag.
// All 128-bit vectors use [0:127] ordering, so index 0 is the MSB. The
// multiplier bit numbering and the >>1 shift therefore match the GCM
// definition directly.
module gcm_tag_verifier (
   input  logic         clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic [0:127] i_h,
   input  logic [0:127] i_encrypted_j0,
   input  logic         i_valid,
   input  logic [0:127] i_data,
   input  logic         i_last,
   input  logic [0:127] i_expected_tag,
   output logic         o_ready,
   output logic         o_busy,
   output logic         o_done,
   output logic [0:127] o_tag,
   output logic         o_auth_ok
);

   // Reduction constant: 11100001 followed by 120 zero bits.
   localparam logic [0:127] R_POLY = {8'he1, 120'd0};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_MULT  = 2'd2,
      S_FINAL = 2'd3
   } state_t;

   state_t       r_state;
   state_t       w_next;

   logic [0:127] r_h;
   logic [0:127] r_ej0;
   logic [0:127] r_s;
   logic [0:127] r_x;
   logic [0:127] r_z;
   logic [0:127] r_v;
   logic [0:127] r_exp_tag;
   logic [0:127] r_tag;
   logic         r_last;
   logic         r_done;
   logic         r_auth_ok;
   logic [6:0]   r_cnt;

   logic [0:127] w_z_next;
   logic [0:127] w_v_next;
   logic [0:127] w_tag_calc;
   logic         w_accept;
   logic         w_mult_end;

   assign w_accept   = (r_state == S_WAIT) && i_valid && !i_start;
   assign w_mult_end = (r_state == S_MULT) && (r_cnt == 7'd127);

   // One multiplier step: conditional accumulate, then shift V with reduction.
   assign w_z_next   = r_x[r_cnt] ? (r_z ^ r_v) : r_z;
   assign w_v_next   = r_v[127] ? ((r_v >> 1) ^ R_POLY) : (r_v >> 1);
   assign w_tag_calc = r_s ^ r_ej0;

   assign o_ready   = (r_state == S_WAIT);
   assign o_busy    = (r_state != S_IDLE);
   assign o_done    = r_done;
   assign o_tag     = r_tag;
   assign o_auth_ok = r_auth_ok;

   // State register.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Next-state logic; i_start restarts the message from any state.
   always_comb begin
      w_next = r_state;
      if (i_start) begin
         w_next = S_WAIT;
      end else begin
         case (r_state)
            S_WAIT:  if (i_valid)    w_next = S_MULT;
            S_MULT:  if (w_mult_end) w_next = r_last ? S_FINAL : S_WAIT;
            S_FINAL: w_next = S_IDLE;
            default: w_next = r_state;
         endcase
      end
   end

   // Datapath: key load, block absorb, 128-step multiply, and tag finalisation.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_h       <= '0;
         r_ej0     <= '0;
         r_s       <= '0;
         r_x       <= '0;
         r_z       <= '0;
         r_v       <= '0;
         r_exp_tag <= '0;
         r_tag     <= '0;
         r_last    <= 1'b0;
         r_done    <= 1'b0;
         r_auth_ok <= 1'b0;
         r_cnt     <= '0;
      end else if (i_start) begin
         r_h       <= i_h;
         r_ej0     <= i_encrypted_j0;
         r_s       <= '0;
         r_tag     <= '0;
         r_auth_ok <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_WAIT: begin
               if (w_accept) begin
                  r_x    <= r_s ^ i_data;
                  r_last <= i_last;
                  if (i_last) r_exp_tag <= i_expected_tag;
                  r_cnt  <= '0;
                  r_z    <= '0;
                  r_v    <= r_h;
               end
            end
            S_MULT: begin
               r_z   <= w_z_next;
               r_v   <= w_v_next;
               r_cnt <= r_cnt + 7'd1;
               if (w_mult_end) r_s <= w_z_next;
            end
            S_FINAL: begin
               r_tag     <= w_tag_calc;
               r_auth_ok <= (w_tag_calc == r_exp_tag);
               r_done    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/gcm_tag_verifier.md
GCM_TAG_VERIFIER -- requirements
Module: gcm_tag_verifier

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port `clk`, input, 1 bit: rising-edge clock for all state.
REQ-003 Port `i_rst_n`, input, 1 bit: asynchronous active-low reset.
REQ-004 Port `i_start`, input, 1 bit: begins a new message and loads `i_h` and `i_encrypted_j0`.
REQ-005 Port `i_h`, input, [0:127]: hash subkey H = E(K, 0^128); bit 0 is the MSB.
REQ-006 Port `i_encrypted_j0`, input, [0:127]: E(K, J0), sampled with `i_start`.
REQ-007 Port `i_valid`, input, 1 bit: `i_data` holds a GHASH input block.
REQ-008 Port `i_data`, input, [0:127]: AAD block, ciphertext block, or final length block (len(A)||len(C), in bits).
REQ-009 Port `i_last`, input, 1 bit: the current `i_data` is the length block.
REQ-010 Port `i_expected_tag`, input, [0:127]: received tag, sampled when the `i_last` block is accepted.
REQ-011 Port `o_ready`, output, 1 bit: the block can accept a data block this cycle.
REQ-012 Port `o_busy`, output, 1 bit: a message is in progress (any state other than IDLE).
REQ-013 Port `o_done`, output, 1 bit: one-cycle pulse when the tag result is valid.
REQ-014 Port `o_tag`, output, [0:127]: computed tag, GHASH result XOR E(K, J0).
REQ-015 Port `o_auth_ok`, output, 1 bit: high when `o_tag` equals the expected tag.

Function
REQ-016 The block SHALL have the states IDLE, WAIT, MULT and FINAL.
REQ-017 Accumulator S and the multiply operands SHALL be 128 bits; there SHALL be no truncation or extension anywhere in the datapath.
REQ-018 `i_start` in any state SHALL:
- load H and EJ0;
- clear S to 0;
- clear `o_auth_ok`, `o_tag` and `o_done`;
- go to WAIT on the next edge.
REQ-019 `i_start` SHALL take priority over `i_valid` in the same cycle; no data block is accepted in that cycle.
REQ-020 `o_ready` SHALL be 1 only in WAIT; `o_busy` SHALL be 1 in WAIT, MULT and FINAL.
REQ-021 A block is accepted when `i_valid` and `o_ready` are both 1. On acceptance the block SHALL:
- latch X = S XOR `i_data`;
- latch `i_last` (and `i_expected_tag` if `i_last` is 1);
- set the bit counter to 0;
- go to MULT.
REQ-022 `i_valid` outside WAIT SHALL be ignored; the source holds data until accepted.
REQ-023 MULT SHALL perform the SP 800-38D bit-serial product, one bit per cycle, for 128 cycles. Initial values are Z=0 and V=H. At step i:
- if X[i]=1 then Z = Z XOR V;
- if V[127]=1 then V = (V>>1) XOR R, otherwise V = V>>1;
- R = 0xE1 followed by 120 zero bits.
REQ-024 At the edge ending the 128th MULT cycle, S SHALL take the final Z. The next state SHALL be FINAL if the latched last flag is 1, otherwise WAIT.
REQ-025 Timing, with the acceptance cycle numbered 0:
- MULT occupies cycles 1 to 128;
- for a non-last block, `o_ready` is 1 again in cycle 129;
- for a last block, FINAL occupies cycle 129.
REQ-026 FINAL SHALL register `o_tag` = S XOR EJ0 and `o_auth_ok` = (S XOR EJ0 == latched expected tag), using a full 128-bit compare. It SHALL pulse `o_done` high in cycle 130 only, and go to IDLE.
REQ-027 `o_tag` and `o_auth_ok` SHALL hold their values after `o_done` until the next `i_start` or reset.
REQ-028 `i_valid` while in IDLE SHALL be ignored; no data is accepted without a preceding `i_start`.
REQ-029 Block throughput SHALL be one block per 129 cycles at most.
REQ-030 A message whose only block is a length block SHALL be legal, giving GHASH = H times that block.

Reset
REQ-031 While `i_rst_n`=0, asynchronously:
- the state SHALL be IDLE;
- S, X, Z, V, H, EJ0, the latched tag and the counter SHALL be 0;
- `o_ready`, `o_busy`, `o_done`, `o_auth_ok` and `o_tag` SHALL be 0.
REQ-032 A reset asserted mid-MULT or mid-FINAL SHALL abort the message with no `o_done` pulse. After release the block SHALL stay in IDLE until `i_start`.

Verification
REQ-033 Reset scenario: assert `i_rst_n`=0 mid-MULT, then release. Required: all outputs 0 immediately, and `o_ready` stays 0 until `i_start`.
REQ-034 Empty-message scenario:
- stimulus: `i_start` with H=66e94bd4ef8a2c3b884cfa59ca342b2e and EJ0=58e2fccefa7e3061367f1d57a4e7455a; then a length block of 0 with `i_last`=1 and expected tag 58e2fccefa7e3061367f1d57a4e7455a;
- required: `o_done` in cycle 130, `o_tag` = 58e2fccefa7e3061367f1d57a4e7455a, `o_auth_ok`=1.
REQ-035 One-block scenario:
- stimulus: same H and EJ0; ciphertext 0388dace60b6a392f328c2b971b2fe78; then length block 00000000000000000000000000000080 with `i_last`=1 and expected tag ab6e47d42cec13bdf53a67b21257bddf;
- required: S = f38cbb1ad69223dcc3457ae5b6b0f885 before FINAL, `o_tag` = ab6e47d42cec13bdf53a67b21257bddf, `o_auth_ok`=1.
REQ-036 Tag-mismatch scenario: repeat REQ-035 with expected tag bit 127 flipped. Required: same `o_tag`, `o_auth_ok`=0, `o_done` still pulses once.
REQ-037 Backpressure scenario: hold `i_valid`=1 with changing `i_data` throughout MULT. Required: `o_ready`=0 for 128 cycles, only the first block is absorbed, and results match REQ-035.
REQ-038 Abort scenario: assert `i_start` in MULT cycle 60, then run the REQ-034 sequence. Required: no `o_done` from the aborted message, S restarts from 0, and REQ-034 results are produced.
